// File: rtl/led_timer_pkg.sv
// ---------------------------------------------------------------------------
// led_timer_pkg
// Shared types and constants for the LED shift timer:
//   state_t   - control FSM states (IDLE, RUN, PAUSE)
//   DIR_*     - shift direction encodings for the dir input
//   MODE_*    - sweep mode encodings for the mode input
// ---------------------------------------------------------------------------
package led_timer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    localparam logic DIR_UP   = 1'b0;  // bit i -> i+1
    localparam logic DIR_DOWN = 1'b1;  // bit i -> i-1

    localparam logic MODE_ROT = 1'b0;  // wrap around at the ends
    localparam logic MODE_PP  = 1'b1;  // bounce at the ends

endpackage

// File: rtl/btn_edge.sv
// ---------------------------------------------------------------------------
// btn_edge
// Rising-edge detector for a synchronous level input. The history register
// resets to 1 so that a level already high when reset is released does not
// produce an edge.
// Ports:
//   clk    in  1  system clock
//   rst_n  in  1  asynchronous active-low reset
//   level  in  1  synchronous level input
//   rise   out 1  high in the cycle where level is 1 and was 0 one cycle ago
// ---------------------------------------------------------------------------
module btn_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise
);

    logic level_q_r;

    // History register: previous-cycle value of the level input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q_r <= 1'b1;
        end else begin
            level_q_r <= level;
        end
    end

    assign rise = level & ~level_q_r;

endmodule

// File: rtl/led_shift_timer_chk.sv
// ---------------------------------------------------------------------------
// led_shift_timer_chk
// Property checker for led_shift_timer outputs.
//   - pattern is one-hot in every cycle out of reset
//   - tick is a single-cycle pulse
// Ports:
//   clk      in  1      system clock
//   rst_n    in  1      asynchronous active-low reset
//   pattern  in  WIDTH  LED pattern under check
//   tick     in  1      step pulse under check
// ---------------------------------------------------------------------------
module led_shift_timer_chk #(
    parameter int WIDTH = 21
) (
    input logic             clk,
    input logic             rst_n,
    input logic [WIDTH-1:0] pattern,
    input logic             tick
);

    a_pattern_onehot: assert property (
        @(posedge clk) disable iff (!rst_n) $onehot(pattern)
    ) else $error("led_shift_timer_chk: pattern %b is not one-hot", pattern);

    a_tick_single: assert property (
        @(posedge clk) disable iff (!rst_n) tick |=> !tick
    ) else $error("led_shift_timer_chk: tick high on two consecutive cycles");

endmodule

// File: rtl/led_shift_timer.sv
// ---------------------------------------------------------------------------
// led_shift_timer
// A single lit LED steps across WIDTH outputs once per programmable period,
// with start / pause / single-step control, direction and speed selects.
//
// Optional feature macro: LED_PINGPONG_EN
//   defined   - mode=1 makes the lit LED bounce at the ends instead of wrapping
//   undefined - mode is ignored, pattern always rotates
//
// Parameters:
//   WIDTH   number of LEDs (>= 2)
//   PERIOD  clk cycles per step at speed=0 (>= 8)
//   CNT_W   period counter width, 2^CNT_W > PERIOD
// Ports:
//   clk          in   1      system clock
//   rst_n        in   1      asynchronous active-low reset
//   start        in   1      level; rising edge starts / resumes
//   pause        in   1      level; rising edge pauses
//   step         in   1      level; rising edge steps once (IDLE/PAUSE only)
//   dir          in   1      0: toward MSB, 1: toward LSB
//   speed        in   2      effective period = PERIOD >> speed
//   mode         in   1      0: rotate, 1: ping-pong
//   pattern_out  out  WIDTH  one-hot LED pattern
//   tick         out  1      pulse in the cycle a new pattern first appears
//   running      out  1      high while in RUN
// ---------------------------------------------------------------------------
module led_shift_timer
    import led_timer_pkg::*;
#(
    parameter int WIDTH  = 21,
    parameter int PERIOD = 20_000_000,
    parameter int CNT_W  = 26
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             pause,
    input  logic             step,
    input  logic             dir,
    input  logic [1:0]       speed,
    input  logic             mode,
    output logic [WIDTH-1:0] pattern_out,
    output logic             tick,
    output logic             running
);

    localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(PERIOD);

    // Rotate the pattern one position in direction d.
    function automatic logic [WIDTH-1:0] shift_pat(input logic [WIDTH-1:0] p,
                                                   input logic             d);
        logic [WIDTH-1:0] r;
        if (d == DIR_UP) begin
            r = {p[WIDTH-2:0], p[WIDTH-1]};
        end else begin
            r = {p[0], p[WIDTH-1:1]};
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Input edge detectors
    // ------------------------------------------------------------------
    logic start_rise_s;
    logic pause_rise_s;
    logic step_rise_s;

    btn_edge u_start_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .level (start),
        .rise  (start_rise_s)
    );

    btn_edge u_pause_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .level (pause),
        .rise  (pause_rise_s)
    );

    btn_edge u_step_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .level (step),
        .rise  (step_rise_s)
    );

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t           state_r;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt;
    logic [WIDTH-1:0] pattern_r;
    logic [WIDTH-1:0] pattern_nxt;
    logic             tick_r;
    logic             running_r;

    logic [CNT_W-1:0] period_s;
    logic             period_done_s;
    logic             do_shift_s;
    logic [WIDTH-1:0] shifted_s;

    assign period_s      = PERIOD_C >> speed;
    assign period_done_s = (cnt_r >= (period_s - CNT_W'(1)));

    // Next-state logic; a pause edge always wins over a start edge.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            IDLE: begin
                if (pause_rise_s) begin
                    state_nxt = IDLE;
                end else if (start_rise_s) begin
                    state_nxt = RUN;
                end else begin
                    state_nxt = IDLE;
                end
            end
            RUN: begin
                if (pause_rise_s) begin
                    state_nxt = PAUSE;
                end else begin
                    state_nxt = RUN;
                end
            end
            PAUSE: begin
                if (pause_rise_s) begin
                    state_nxt = PAUSE;
                end else if (start_rise_s) begin
                    state_nxt = RUN;
                end else begin
                    state_nxt = PAUSE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Period counter and shift request.
    // In RUN a due step is deferred by one cycle while tick is still high:
    // this keeps tick a single-cycle pulse when P=1, and when a manual step
    // and a resume coincide with a counter already at its limit.
    always_comb begin
        cnt_nxt    = cnt_r;
        do_shift_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_rise_s && !pause_rise_s) begin
                    cnt_nxt = '0;
                end else begin
                    cnt_nxt = cnt_r;
                end
                do_shift_s = step_rise_s;
            end
            RUN: begin
                if (pause_rise_s) begin
                    cnt_nxt = cnt_r;
                end else if (period_done_s && !tick_r) begin
                    cnt_nxt    = '0;
                    do_shift_s = 1'b1;
                end else if (period_done_s) begin
                    cnt_nxt = cnt_r;
                end else begin
                    cnt_nxt = cnt_r + CNT_W'(1);
                end
            end
            PAUSE: begin
                cnt_nxt    = cnt_r;
                do_shift_s = step_rise_s;
            end
            default: begin
                cnt_nxt    = '0;
                do_shift_s = 1'b0;
            end
        endcase
    end

`ifdef LED_PINGPONG_EN
    logic sweep_r;
    logic sweep_nxt;
    logic dir_raw_s;
    logic flip_pre_s;
    logic dir_eff_s;
    logic flip_post_s;

    // True when the lit bit already sits at the end it would move toward.
    function automatic logic at_end(input logic [WIDTH-1:0] p, input logic d);
        logic r;
        if (d == DIR_UP) begin
            r = p[WIDTH-1];
        end else begin
            r = p[0];
        end
        return r;
    endfunction

    // Ping-pong shift. If the bit is already at the end (mode just switched
    // on there) the direction reverses before moving, so no wrap can occur;
    // landing on an end arms sweep so the following step reverses.
    always_comb begin
        dir_raw_s   = dir ^ sweep_r;
        flip_pre_s  = at_end(pattern_r, dir_raw_s);
        dir_eff_s   = dir_raw_s ^ flip_pre_s;
        shifted_s   = shift_pat(pattern_r, dir);
        flip_post_s = 1'b0;
        sweep_nxt   = sweep_r;
        if (mode == MODE_PP) begin
            shifted_s   = shift_pat(pattern_r, dir_eff_s);
            flip_post_s = at_end(shifted_s, dir_eff_s);
            if (do_shift_s) begin
                sweep_nxt = sweep_r ^ flip_pre_s ^ flip_post_s;
            end else begin
                sweep_nxt = sweep_r;
            end
        end else begin
            sweep_nxt = 1'b0;
        end
    end

    // Sweep direction register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sweep_r <= 1'b0;
        end else begin
            sweep_r <= sweep_nxt;
        end
    end
`else
    logic unused_mode_s;
    assign unused_mode_s = mode;

    // Plain rotation in the requested direction.
    always_comb begin
        shifted_s = shift_pat(pattern_r, dir);
    end
`endif

    // Pattern update selection.
    always_comb begin
        if (do_shift_s) begin
            pattern_nxt = shifted_s;
        end else begin
            pattern_nxt = pattern_r;
        end
    end

    // State, counter, pattern and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            pattern_r <= WIDTH'(1);
            tick_r    <= 1'b0;
            running_r <= 1'b0;
        end else begin
            state_r   <= state_nxt;
            cnt_r     <= cnt_nxt;
            pattern_r <= pattern_nxt;
            tick_r    <= do_shift_s;
            running_r <= (state_nxt == RUN);
        end
    end

    assign pattern_out = pattern_r;
    assign tick        = tick_r;
    assign running     = running_r;

endmodule

// File: tb/tb_led_shift_timer.sv
module tb_led_shift_timer;

    localparam int WIDTH  = 5;
    localparam int PERIOD = 8;
    localparam int CNT_W  = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             pause;
    logic             step;
    logic             dir;
    logic [1:0]       speed;
    logic             mode;
    logic [WIDTH-1:0] pattern_out;
    logic             tick;
    logic             running;

    int n_err;
    int n_chk;

    typedef struct {
        logic             start;
        logic             pause;
        logic             step;
        logic             dir;
        logic [1:0]       speed;
        logic             mode;
        logic [WIDTH-1:0] exp_pat;
        logic             exp_tick;
        logic             exp_run;
    } vec_t;

    vec_t vecs[$];

    led_shift_timer #(
        .WIDTH  (WIDTH),
        .PERIOD (PERIOD),
        .CNT_W  (CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .pause       (pause),
        .step        (step),
        .dir         (dir),
        .speed       (speed),
        .mode        (mode),
        .pattern_out (pattern_out),
        .tick        (tick),
        .running     (running)
    );

    led_shift_timer_chk #(
        .WIDTH (WIDTH)
    ) u_chk (
        .clk     (clk),
        .rst_n   (rst_n),
        .pattern (pattern_out),
        .tick    (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mkv(input logic s, input logic p, input logic st,
                                 input logic d, input logic [1:0] sp, input logic m,
                                 input logic [WIDTH-1:0] ep, input logic et,
                                 input logic er);
        vec_t v;
        v.start = s;  v.pause = p;  v.step = st;
        v.dir = d;    v.speed = sp; v.mode = m;
        v.exp_pat = ep; v.exp_tick = et; v.exp_run = er;
        return v;
    endfunction

    task automatic add(input logic s, input logic p, input logic st, input logic d,
                       input logic [1:0] sp, input logic [WIDTH-1:0] ep,
                       input logic et, input logic er);
        vecs.push_back(mkv(s, p, st, d, sp, 1'b0, ep, et, er));
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic [WIDTH-1:0] ep,
                              input logic et, input logic er);
        chk({tag, " pattern"}, 32'(pattern_out), 32'(ep));
        chk({tag, " tick"},    32'(tick),        32'(et));
        chk({tag, " running"}, 32'(running),     32'(er));
    endtask

    // Drive one vector just after a falling edge, clock it in, check at the next falling edge.
    task automatic run_vec(input vec_t v, input string tag);
        start = v.start; pause = v.pause; step = v.step;
        dir = v.dir; speed = v.speed; mode = v.mode;
        @(posedge clk);
        @(negedge clk);
        check_outs(tag, v.exp_pat, v.exp_tick, v.exp_run);
    endtask

    logic [WIDTH-1:0] pp_exp [9];

    initial begin
        n_err = 0;
        n_chk = 0;

        // ---------------- table: tests 1..4 ----------------
        // start held through reset must not fire
        add(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 5'b00001, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'b00001, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 5'b00001, 1'b0, 1'b1);
        // test 1: tick every 8 cycles, full rotation toward MSB
        for (int k = 1; k <= 5; k++) begin
            for (int q = 0; q < 7; q++)
                add(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'(1 << ((k - 1) % 5)), 1'b0, 1'b1);
            add(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'(1 << (k % 5)), 1'b1, 1'b1);
        end
        // test 2: three counts into the period, pause for 20 cycles, resume
        for (int q = 0; q < 3; q++)
            add(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'b00001, 1'b0, 1'b1);
        for (int q = 0; q < 20; q++)
            add(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 5'b00001, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 5'b00001, 1'b0, 1'b1);
        for (int q = 0; q < 4; q++)
            add(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'b00001, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 5'b00010, 1'b1, 1'b1);
        // test 3: step ignored in RUN, then steps with dir=1 in PAUSE
        add(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 5'b00010, 1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 5'b00010, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 5'b00001, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 5'b00001, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b1, 2'd0, 5'b10000, 1'b1, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 5'b10000, 1'b0, 1'b0);
        // test 4: resume with cnt=1, reach cnt=6, switch to speed=2
        add(1'b1, 1'b0, 1'b0, 1'b1, 2'd0, 5'b10000, 1'b0, 1'b1);
        for (int q = 0; q < 5; q++)
            add(1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 5'b10000, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 5'b01000, 1'b1, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 5'b01000, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 5'b00100, 1'b1, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 5'b00100, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b1, 2'd2, 5'b00010, 1'b1, 1'b1);

`ifdef LED_PINGPONG_EN
        pp_exp = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b01000,
                   5'b00100, 5'b00010, 5'b00001, 5'b00010};
`else
        pp_exp = '{5'b00010, 5'b00100, 5'b01000, 5'b10000, 5'b00001,
                   5'b00010, 5'b00100, 5'b01000, 5'b10000};
`endif

        // ---------------- reset ----------------
        rst_n = 1'b0;
        start = 1'b1; pause = 1'b0; step = 1'b0;
        dir = 1'b0; speed = 2'd0; mode = 1'b0;
        repeat (2) @(negedge clk);
        check_outs("reset", 5'b00001, 1'b0, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            run_vec(vecs[i], $sformatf("vec%0d", i));

        // ---------------- test 5: async reset mid-run ----------------
        #2;
        rst_n = 1'b0;
        #1;
        check_outs("async_reset", 5'b00001, 1'b0, 1'b0);
        start = 1'b0; pause = 1'b0; step = 1'b0; dir = 1'b0; speed = 2'd0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(mkv(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 5'b00001, 1'b0, 1'b0), "idle_quiet");
        run_vec(mkv(1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 5'b00001, 1'b0, 1'b0), "start_pause_same");
        for (int q = 0; q < 10; q++)
            run_vec(mkv(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 5'b00001, 1'b0, 1'b0),
                    $sformatf("stay_idle%0d", q));

        // ---------------- test 6: mode=1 manual steps toward MSB ----------------
        for (int k = 0; k < 9; k++) begin
            run_vec(mkv(1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b1, pp_exp[k], 1'b1, 1'b0),
                    $sformatf("sweep%0d", k));
            run_vec(mkv(1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1, pp_exp[k], 1'b0, 1'b0),
                    $sformatf("sweep%0d_hold", k));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
